// File: rtl/cas_pkg.sv
// Shared types and helpers for the cassette playback engine.
package cas_pkg;

    localparam int CAS_BYTE_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEADER = 3'd1,
        FETCH  = 3'd2,
        LOAD   = 3'd3,
        BIT_HI = 3'd4,
        BIT_LO = 3'd5,
        DONE   = 3'd6
    } cas_state_t;

    // Bits needed to hold any value up to max(a,b).
    function automatic int cas_cnt_w(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/cas_bit_timer.sv
// Half-period down-counter; expired is high once the count reaches zero.
module cas_bit_timer #(
    parameter int CNT_W = 11
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/cas_player.sv
// Cassette playback engine: BRAM bytes -> MSB-first pulse-width tape signal.
// Define CAS_PLAYER_LEADER_EN to emit a LEADER_BITS run of 1 bits before the data.
module cas_player
    import cas_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int HALF0_CYC   = 1136,
    parameter int HALF1_CYC   = 568,
    parameter int LEADER_BITS = 256
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              play,
    input  logic              rewind,
    input  logic [ADDR_W:0]   tape_len,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    output logic              tape_out,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr
);

    localparam int CNT_W = cas_cnt_w(HALF0_CYC, HALF1_CYC);
    localparam int BIT_W = $clog2(CAS_BYTE_BITS);
    localparam logic [CNT_W-1:0]  LD0     = CNT_W'(HALF0_CYC - 1);
    localparam logic [CNT_W-1:0]  LD1     = CNT_W'(HALF1_CYC - 1);
    localparam logic [ADDR_W:0]   MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    if (DATA_W != CAS_BYTE_BITS || LEADER_BITS < 1) begin : g_param_chk
        $error("cas_player: DATA_W must be 8 and LEADER_BITS at least 1");
    end

    cas_state_t         state, state_n;
    logic [ADDR_W:0]    ptr, ptr_n, len_q, len_n;
    logic [DATA_W-1:0]  sreg, sreg_n;
    logic [BIT_W-1:0]   bcnt, bcnt_n;
    logic               t_clr, t_load, t_en, t_exp, adv, tape_n;
    logic [CNT_W-1:0]   t_val;

`ifdef CAS_PLAYER_LEADER_EN
    localparam int LEAD_W = cas_cnt_w(LEADER_BITS, 1);
    logic              lead_hi, lead_hi_n;
    logic [LEAD_W-1:0] lead_cnt, lead_cnt_n;
`endif

    function automatic logic [CNT_W-1:0] half_ld(input logic b);
        return b ? LD1 : LD0;
    endfunction

    cas_bit_timer #(.CNT_W(CNT_W)) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (t_clr),
        .load    (t_load),
        .load_val(t_val),
        .en      (t_en),
        .expired (t_exp)
    );

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        len_n   = len_q;
        sreg_n  = sreg;
        bcnt_n  = bcnt;
        t_clr   = 1'b0;
        t_load  = 1'b0;
        t_en    = 1'b0;
        t_val   = LD0;
        adv     = play && t_exp;
`ifdef CAS_PLAYER_LEADER_EN
        lead_hi_n  = lead_hi;
        lead_cnt_n = lead_cnt;
`endif
        if (rewind) begin
            state_n = IDLE;
            ptr_n   = '0;
            bcnt_n  = '0;
            t_clr   = 1'b1;
`ifdef CAS_PLAYER_LEADER_EN
            lead_hi_n  = 1'b0;
            lead_cnt_n = '0;
`endif
        end else begin
            case (state)
                IDLE: if (play) begin
                    len_n = (tape_len > MAX_LEN) ? MAX_LEN : tape_len;
                    if (tape_len == '0)
                        state_n = DONE;
                    else begin
`ifdef CAS_PLAYER_LEADER_EN
                        state_n    = LEADER;
                        lead_hi_n  = 1'b1;
                        lead_cnt_n = LEAD_W'(LEADER_BITS - 1);
                        t_load     = 1'b1;
                        t_val      = LD1;
`else
                        state_n = FETCH;
`endif
                    end
                end
`ifdef CAS_PLAYER_LEADER_EN
                // mem_addr has sat at byte 0 throughout the leader, so mem_q
                // already holds it and the first data bit follows with no gap.
                LEADER: begin
                    t_en = play;
                    if (adv) begin
                        t_load = 1'b1;
                        t_val  = LD1;
                        if (lead_hi)
                            lead_hi_n = 1'b0;
                        else if (lead_cnt != '0) begin
                            lead_hi_n  = 1'b1;
                            lead_cnt_n = lead_cnt - 1'b1;
                        end else begin
                            sreg_n  = mem_q;
                            bcnt_n  = BIT_W'(CAS_BYTE_BITS - 1);
                            t_val   = half_ld(mem_q[DATA_W-1]);
                            state_n = BIT_HI;
                        end
                    end
                end
`endif
                FETCH: state_n = LOAD;
                LOAD: begin
                    sreg_n  = mem_q;
                    bcnt_n  = BIT_W'(CAS_BYTE_BITS - 1);
                    t_load  = 1'b1;
                    t_val   = half_ld(mem_q[DATA_W-1]);
                    state_n = BIT_HI;
                end
                BIT_HI: begin
                    t_en = play;
                    if (adv) begin
                        t_load  = 1'b1;
                        t_val   = half_ld(sreg[DATA_W-1]);
                        state_n = BIT_LO;
                    end
                end
                BIT_LO: begin
                    t_en = play;
                    if (adv) begin
                        if (bcnt != '0) begin
                            sreg_n  = {sreg[DATA_W-2:0], 1'b0};
                            bcnt_n  = bcnt - 1'b1;
                            t_load  = 1'b1;
                            t_val   = half_ld(sreg[DATA_W-2]);
                            state_n = BIT_HI;
                        end else begin
                            ptr_n   = ptr + 1'b1;
                            state_n = (ptr_n < len_q) ? FETCH : DONE;
                        end
                    end
                end
                DONE: ;
                default: state_n = IDLE;
            endcase
        end
        // Registered output: a paused high half reads as low.
`ifdef CAS_PLAYER_LEADER_EN
        tape_n = play && (state_n == BIT_HI || (state_n == LEADER && lead_hi_n));
`else
        tape_n = play && (state_n == BIT_HI);
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            len_q    <= '0;
            sreg     <= '0;
            bcnt     <= '0;
            tape_out <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            len_q    <= len_n;
            sreg     <= sreg_n;
            bcnt     <= bcnt_n;
            tape_out <= tape_n;
        end
    end

`ifdef CAS_PLAYER_LEADER_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lead_hi  <= 1'b0;
            lead_cnt <= '0;
        end else begin
            lead_hi  <= lead_hi_n;
            lead_cnt <= lead_cnt_n;
        end
    end
`endif

    assign mem_addr = ptr[ADDR_W-1:0];
    assign cur_addr = ptr[ADDR_W-1:0];
    assign busy     = (state != IDLE) && (state != DONE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_cas_player.sv
// Scoreboard bench: expected tape_out runs are queued, a monitor checks each run.
module tb_cas_player;

    localparam int ADDR_W = 4;
`ifdef CAS_PLAYER_LEADER_EN
    localparam int PRE = 1 + 64;
`else
    localparam int PRE = 3;
`endif

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              play = 1'b0;
    logic              rewind = 1'b0;
    logic [ADDR_W:0]   tape_len = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_q;
    logic              tape_out, busy, done;
    logic [ADDR_W-1:0] cur_addr;

    logic [7:0] mem [16];
    int n_pass = 0;
    int n_tot  = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic lvl;
        int   len;
    } run_t;
    run_t exp_q[$];

    cas_player #(
        .ADDR_W(ADDR_W), .DATA_W(8), .HALF0_CYC(4), .HALF1_CYC(8), .LEADER_BITS(4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .play    (play),
        .rewind  (rewind),
        .tape_len(tape_len),
        .mem_addr(mem_addr),
        .mem_q   (mem_q),
        .tape_out(tape_out),
        .busy    (busy),
        .done    (done),
        .cur_addr(cur_addr)
    );

    always #5 clock = ~clock;

    always @(posedge clock) mem_q <= mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tot++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    endtask

    // Monitor: measures each constant-level run of tape_out and scores it.
    int   run_len = 0;
    logic prev = 1'b0;
    always @(negedge clock) begin
        if (!mon_en) begin
            run_len = 0;
        end else if (run_len == 0) begin
            prev = tape_out;
            run_len = 1;
        end else if (tape_out !== prev) begin
            if (exp_q.size() == 0) begin
                n_tot++;
                $display("FAIL run_extra: got level %0d len %0d expected none", prev, run_len);
            end else begin
                run_t e;
                e = exp_q.pop_front();
                chk("run_level", 32'(prev), 32'(e.lvl));
                chk("run_len", run_len, e.len);
            end
            prev = tape_out;
            run_len = 1;
        end else begin
            run_len++;
        end
    end

    task automatic push(input logic l, input int n);
        run_t r;
        r.lvl = l;
        r.len = n;
        exp_q.push_back(r);
    endtask

    // gap < 0: final byte, its last low half never ends so it is not queued.
    task automatic push_byte(input logic [7:0] b, input int gap);
        for (int i = 7; i >= 0; i--) begin
            int h;
            h = b[i] ? 8 : 4;
            push(1'b1, h);
            if (i > 0) push(1'b0, h);
            else if (gap >= 0) push(1'b0, h + gap);
        end
    endtask

    task automatic push_start();
`ifdef CAS_PLAYER_LEADER_EN
        push(1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 8);
            push(1'b0, 8);
        end
`else
        push(1'b0, 3);
`endif
    endtask

    task automatic start(input int len);
        tape_len = (ADDR_W+1)'(len);
        play = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic wait_done(input int from, input int limit, output int j);
        j = from;
        forever begin
            @(negedge clock);
            if (done || j > limit) break;
            j++;
        end
    endtask

    task automatic finish_test();
        mon_en = 1'b0;
        chk("runs_drained", exp_q.size(), 0);
        play = 1'b0;
        rewind = 1'b1;
        @(posedge clock); #1 rewind = 1'b0;
        @(posedge clock); #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_cur_addr", cur_addr, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int j;
        foreach (mem[i]) mem[i] = 8'h00;
        @(negedge clock);
        chk("rst_tape_out", tape_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_cur_addr", cur_addr, 0);
        @(posedge clock); #1 reset_n = 1'b1;
        @(posedge clock); #1;

        // single byte 0xA5
        mem[0] = 8'hA5;
        push_start();
        push_byte(8'hA5, -1);
        start(1);
        wait_done(0, 600, j);
        chk("basic_done_time", j, PRE + 96);
        chk("basic_busy_in_done", busy, 0);
        chk("basic_tape_low", tape_out, 0);
        chk("basic_cur_addr", cur_addr, 1);
        finish_test();

        // two bytes with inter-byte gap
        mem[0] = 8'h00; mem[1] = 8'hFF;
        push_start();
        push_byte(8'h00, 2);
        push_byte(8'hFF, -1);
        start(2);
        repeat (11) @(negedge clock);
        chk("multi_addr_byte0", mem_addr, 0);
        repeat (PRE + 66) @(negedge clock);
        chk("multi_addr_byte1", mem_addr, 1);
        wait_done(PRE + 77, 900, j);
        chk("multi_done_time", j, PRE + 194);
        finish_test();

        // pause 10 cycles after 3 cycles of a 1-bit high half
        mem[0] = 8'hFF;
        push_start();
        push(1'b1, 3); push(1'b0, 10); push(1'b1, 5); push(1'b0, 8);
        for (int i = 6; i >= 0; i--) begin
            push(1'b1, 8);
            if (i > 0) push(1'b0, 8);
        end
        start(1);
        repeat (PRE + 2) @(posedge clock); #1 play = 1'b0;
        repeat (10) @(posedge clock); #1 play = 1'b1;
        wait_done(PRE + 12, 900, j);
        chk("pause_done_time", j, PRE + 138);
        finish_test();

        // rewind during the second byte's first high half
        mem[0] = 8'h81; mem[1] = 8'hFF;
        push_start();
        push_byte(8'h81, 2);
        push(1'b1, 6);
        push_start();
        push_byte(8'h81, 2);
        push_byte(8'hFF, -1);
        start(2);
        repeat (PRE + 87) @(posedge clock); #1 rewind = 1'b1;
        @(posedge clock); #1 rewind = 1'b0;
        @(negedge clock);
        chk("rew_busy", busy, 0);
        chk("rew_cur_addr", cur_addr, 0);
        chk("rew_tape_out", tape_out, 0);
        @(negedge clock);
        chk("rew_restart_busy", busy, 1);
        chk("rew_restart_addr", mem_addr, 0);
        wait_done(PRE + 90, 1500, j);
        chk("rew_done_time", j, 2 * PRE + 298);
        finish_test();

        // empty tape: straight to DONE, no pulses; play ignored in DONE
        start(0);
        wait_done(0, 20, j);
        chk("zero_done_time", j, 1);
        repeat (5) @(negedge clock);
        chk("zero_tape_out", tape_out, 0);
        chk("zero_busy", busy, 0);
        chk("zero_done_held", done, 1);
        finish_test();

        // asynchronous reset mid-bit
        mem[0] = 8'hA5;
        push_start();
        start(1);
        repeat (PRE + 3) @(negedge clock);
        chk("arst_pre_tape", tape_out, 1);
        chk("arst_pre_busy", busy, 1);
        mon_en = 1'b0;
        chk("arst_runs_drained", exp_q.size(), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_tape_out", tape_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_cur_addr", cur_addr, 0);
        play = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/cas_player.md
# cas_player

Cassette playback engine for the cassette overlay. Reads a loaded tape image byte-by-byte from the read port of the cassette dual-port BRAM and serialises it, MSB first, into a pulse-width-encoded tape signal for the core's cassette input. Provides play/pause, rewind, end-of-tape detection and a current-position output for the overlay display.

## Interface
Parameters:
- ADDR_W, 16: BRAM address width; tape image holds at most 2**ADDR_W bytes.
- DATA_W, 8: BRAM word width; fixed at 8 for this block.
- HALF0_CYC, 1136: clock cycles per half-period of a 0 bit.
- HALF1_CYC, 568: clock cycles per half-period of a 1 bit.
- LEADER_BITS, 256: leader length in 1 bits; used only with CAS_PLAYER_LEADER_EN.

Ports:
- clock, in, 1: single clock.
- reset_n, in, 1: asynchronous active-low reset.
- play, in, 1: level; 1 = run, 0 = pause.
- rewind, in, 1: one-cycle pulse; return to start.
- tape_len, in, ADDR_W+1: image length in bytes; sampled on leaving IDLE.
- mem_addr, out, ADDR_W: BRAM read address, registered.
- mem_q, in, 8: BRAM read data, valid one cycle after mem_addr is presented.
- tape_out, out, 1: serial tape signal, registered.
- busy, out, 1: high in any state except IDLE and DONE.
- done, out, 1: high in DONE.
- cur_addr, out, ADDR_W: byte pointer.

## Operation
- States: IDLE, LEADER (macro only), FETCH, LOAD, BIT_HI, BIT_LO, DONE.
- IDLE: if play=1 and tape_len=0, go to DONE. If play=1 and tape_len>0, go to FETCH, or to LEADER with the macro.
- FETCH: mem_addr equals ptr; the BRAM registers data at the end of this cycle.
- LOAD: shift register captures mem_q; bit counter is set to 7.
- BIT_HI: tape_out=1 for HALFx_CYC cycles, where x is the current MSB. Then go to BIT_LO.
- BIT_LO: tape_out=0 for the same HALFx_CYC cycles. Then:
  - if bits remain, shift and go to BIT_HI;
  - otherwise ptr++, then go to FETCH if ptr<tape_len, else DONE.
- DONE: tape_out=0 and the block holds here until rewind. play is ignored.
- Pause: while play=0 in BIT_HI, BIT_LO or LEADER:
  - state and half-period counter freeze;
  - tape_out is forced to 0;
  - on resume, the remaining count continues from where it froze.
- FETCH/LOAD complete regardless of play.
- rewind has priority over everything, including play in the same cycle. Next cycle: ptr=0, state IDLE, tape_out=0, counters cleared.
- Widths:
  - ptr is ADDR_W+1 bits and is compared against tape_len at full width.
  - mem_addr and cur_addr are ptr[ADDR_W-1:0].
  - tape_len > 2**ADDR_W is clamped to 2**ADDR_W.
- Half-period counter width is $clog2(max(HALF0_CYC,HALF1_CYC)+1).

## Timing
- Reset values: tape_out=0, busy=0, done=0, mem_addr=0, cur_addr=0, state IDLE.
- play is sampled high at edge E. FETCH is entered at E+1, LOAD at E+2, BIT_HI at E+3, and tape_out rises at E+3.
- Each bit occupies exactly 2*HALFx_CYC cycles.
- Inter-byte gap: 2 extra tape_out=0 cycles (FETCH, LOAD) appended to the final low half of each byte.
- After the last bit of the last byte, DONE and done=1 are asserted on the edge that ends BIT_LO.
- Reset mid-operation returns all outputs to reset values immediately. This is asynchronous; there is no partial-byte resume.

## Configuration
- CAS_PLAYER_LEADER_EN defined: before the first byte after IDLE, the block emits LEADER_BITS 1 bits using HALF1_CYC timing in state LEADER. Pause applies during the leader. A rewind issued during the leader restarts it.
- Not defined: LEADER state and its counter are absent; IDLE goes directly to FETCH.

## Structure
- cas_pkg holds:
  - state enum cas_state_t;
  - localparam CAS_BYTE_BITS=8;
  - helper function for counter-width computation.
- Sub-module cas_bit_timer:
  - half-period down-counter with load, enable (play) and clear;
  - outputs `expired`;
  - used for bit halves and the leader.
- cas_player owns the FSM, pointer, shift register and outputs.

## Test plan
Bench parameters: HALF0_CYC=4, HALF1_CYC=8; BRAM model has 1-cycle read latency.
- Basic: image {0xA5}, tape_len=1, play=1 held.
  - tape_out rises 3 cycles after play.
  - Pattern per bit: 1 0 1 0 0 1 0 1 with halves 8,4,8,4,4,8,4,8.
  - done=1 after 96 bit cycles; busy low in DONE.
- Multi-byte: image {0x00,0xFF}, tape_len=2. Exactly 2 extra low cycles appear between bytes, and mem_addr steps 0→1. Total length: 64 + 2 + 128 cycles after the first rise.
- Pause: drop play for 10 cycles midway through a 1-bit high half (after 3 cycles). tape_out is 0 during the pause, then high for the remaining 5 cycles.
- Rewind: pulse rewind with play=1 during byte 1. Next cycle: state IDLE, cur_addr=0, tape_out=0. Playback restarts from byte 0 in the following cycle.
- Boundaries:
  - tape_len=0 with play: done=1 one cycle later, tape_out never rises.
  - async reset_n low mid-bit: all outputs zero without a clock edge.
- Macro: CAS_PLAYER_LEADER_EN with LEADER_BITS=4. Four 16-cycle 1-bit periods precede the first data bit, with no gap.
